control_cuenta1: RTL and testbench
==================================

# control_cuenta1

Sequencer on the initiator side of the `cuenta1` start/valor/cuenta/fin handshake. On command it sweeps `valor` from 0 to a programmed limit. For each value it pulses `start`, waits for `fin`, then captures `cuenta`. It checks each capture against `valor`, accumulates a running sum, and flags mismatches or a counter that never finishes. It sits between top-level control and a `cuenta1` instance, so it can drive and self-check that counter in system or on the bench.

## Interface
- `TIMEOUT`, default 16: cycles spent in ESPERA without `fin` before the item is aborted.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs immediately.
- `ir` in 1: run request; sampled only in REPOSO.
- `n_valores` in 3: last `valor` of the sweep; latched when `ir` is accepted.
- `valor` out 3: value presented to the counter; stable from the `start` cycle until `fin` or timeout.
- `start` out 1: one-cycle pulse per item.
- `cuenta` in 4: counter result; valid in the cycle `fin` is high.
- `fin` in 1: counter completion.
- `ocupado` out 1: high in every state except REPOSO.
- `hecho` out 1: one-cycle pulse at the end of a sweep.
- `suma` out 7: sum of all captured `cuenta` values in the current sweep.
- `ultima` out 4: most recently captured `cuenta`.
- `error` out 1: sticky within a sweep; cleared when the next `ir` is accepted.

## Operation
- States: REPOSO, LANZA, ESPERA, FIN.
- REPOSO, `ir`=1:
  - latch `n_valores` into `limite`;
  - set `valor`=0;
  - clear `suma`, `ultima`, `error` and the timeout counter;
  - go to LANZA.
- REPOSO, `ir`=0: remain in REPOSO.
- LANZA: `start`=1 for exactly this cycle; clear the timeout counter; go to ESPERA.
- ESPERA, `fin`=1:
  - `ultima`<=`cuenta`;
  - `suma`<=`suma`+`cuenta` (7-bit; maximum 8x15=120, so it never overflows);
  - if `cuenta` != {1'b0,`valor`}, set `error`.
  - Then, if `valor`==`limite`, go to FIN; otherwise `valor`<=`valor`+1 and go to LANZA.
- ESPERA, `fin`=0: increment the timeout counter. When it reaches `TIMEOUT`:
  - set `error`;
  - leave `suma` and `ultima` unchanged;
  - go to FIN (abort the remainder of the sweep).
- FIN: `hecho`=1 for one cycle; go to REPOSO.
- The end-of-sweep check happens before the increment, so `valor` never wraps (limit 7 ends at 7).
- A mismatch does not abort; the sweep continues.
- `ir` is ignored while `ocupado` is high.

## Timing
- Reset values: `start`=0, `valor`=0, `ocupado`=0, `hecho`=0, `suma`=0, `ultima`=0, `error`=0; state=REPOSO.
- `reset` asserted mid-sweep:
  - `start` drops asynchronously;
  - no `hecho` pulse is produced;
  - the next run starts only on a fresh `ir` after `reset` is released.
- `ir` to `start`: 1 cycle (REPOSO→LANZA, then `start` is high during LANZA).
- `start` is registered; `fin` is sampled from the first ESPERA cycle onward.
  - The counter clears `fin` on the edge that samples `start`, so a stale `fin` is never seen.
- `fin` to next `start`: exactly 1 cycle (ESPERA→LANZA).
- `fin` to `hecho` on the last item: 1 cycle.
- Per-item overhead beyond counter latency: 2 cycles (LANZA + the capture edge).
- `ultima`, `suma` and `error` update on the edge where `fin` is sampled high.
- `fin` asserted during LANZA is ignored.
- `fin` and timeout reached in the same cycle: `fin` wins and the item is captured normally.
- Outputs are registered except `ocupado`, which is decoded from state.

## Structure
- Shared header `cuenta1_defs.vh` holds:
  - state encodings (2-bit);
  - widths `W_VALOR`=3, `W_CUENTA`=4, `W_SUMA`=7;
  - the default `TIMEOUT`.
  - `cuenta1` and its bench include the same header.
- One sub-module, `temporizador`:
  - inputs `clk`, `reset`, `borrar`, `habilitar`;
  - parameter `TIMEOUT`;
  - output `vencido`;
  - counter width = clog2(TIMEOUT+1).
- FSM, datapath registers (`valor`, `suma`, `ultima`, `error`, `limite`) and output logic live in `control_cuenta1`.

## Test plan
- Behavioural counter returning `cuenta`=`valor` after `valor`+1 cycles; `n_valores`=3, pulse `ir`:
  - expect 4 `start` pulses with `valor` 0,1,2,3;
  - `suma`=6, `ultima`=3, `error`=0;
  - one `hecho` pulse.
- `n_valores`=7, same model:
  - expect `valor` 0..7 with no wrap to 0;
  - `suma`=28, `hecho` one cycle after the 8th `fin`.
- Model returns 3 when `valor`=2, `n_valores`=4:
  - `error`=1 from that capture and stays high;
  - all 5 items are still run; `suma`=11.
- Model never asserts `fin`, `TIMEOUT`=16:
  - `error`=1 after 16 ESPERA cycles, then `hecho`, then REPOSO;
  - `suma`=0.
- `reset` pulsed mid-ESPERA of item 2:
  - all outputs 0 immediately, no `hecho`;
  - a new `ir` runs a clean sweep.
- `ir` held high throughout the sweep: no restart while `ocupado`; a new sweep starts only from REPOSO.

Source files
------------

// File: rtl/control_cuenta1_pkg.sv
// Shared definitions for the cuenta1 initiator: widths, state encoding,
// default timeout and the capture check.
package control_cuenta1_pkg;

    localparam int W_VALOR     = 3;
    localparam int W_CUENTA    = 4;
    localparam int W_SUMA      = 7;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        LANZA  = 2'd1,
        ESPERA = 2'd2,
        FIN    = 2'd3
    } estado_t;

    // A capture is correct when the counter echoes the value it was given.
    function automatic logic coincide(input logic [W_CUENTA-1:0] cuenta,
                                      input logic [W_VALOR-1:0]  valor);
        return cuenta == {1'b0, valor};
    endfunction

endpackage

// File: rtl/control_cuenta1_temporizador.sv
// Watchdog for the ESPERA state: counts enabled cycles and flags the one on
// which the count reaches TIMEOUT.
module temporizador
    import control_cuenta1_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic borrar,
    input  logic habilitar,
    output logic vencido
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Saturates at TIMEOUT so a long idle wait never wraps back to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (borrar) begin
            cnt <= '0;
        end else if (habilitar && (cnt != CW'(TIMEOUT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign vencido = habilitar && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/control_cuenta1.sv
// Sweeps valor 0..limite through a cuenta1 counter, checking and summing
// every result and aborting an item whose fin never arrives.
module control_cuenta1
    import control_cuenta1_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ir,
    input  logic [W_VALOR-1:0]  n_valores,
    output logic [W_VALOR-1:0]  valor,
    output logic                start,
    input  logic [W_CUENTA-1:0] cuenta,
    input  logic                fin,
    output logic                ocupado,
    output logic                hecho,
    output logic [W_SUMA-1:0]   suma,
    output logic [W_CUENTA-1:0] ultima,
    output logic                error
);

    estado_t              estado;
    estado_t              estado_sig;
    logic [W_VALOR-1:0]   limite;
    logic                 start_sig;
    logic                 hecho_sig;
    logic                 vencido;
    logic                 borrar_tmp;
    logic                 habilitar_tmp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado <= REPOSO;
        end else begin
            estado <= estado_sig;
        end
    end

    // The end-of-sweep test precedes the increment, so valor never wraps.
    always_comb begin
        estado_sig = estado;
        unique case (estado)
            REPOSO: if (ir) estado_sig = LANZA;
            LANZA:  estado_sig = ESPERA;
            ESPERA: begin
                if (fin) begin
                    estado_sig = (valor == limite) ? FIN : LANZA;
                end else if (vencido) begin
                    estado_sig = FIN;
                end
            end
            FIN:    estado_sig = REPOSO;
            default: estado_sig = REPOSO;
        endcase
    end

    always_comb begin
        start_sig = (estado_sig == LANZA);
        hecho_sig = (estado_sig == FIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start <= 1'b0;
            hecho <= 1'b0;
        end else begin
            start <= start_sig;
            hecho <= hecho_sig;
        end
    end

    assign ocupado = (estado != REPOSO);

    assign borrar_tmp    = ((estado == REPOSO) && ir) || (estado == LANZA);
    assign habilitar_tmp = (estado == ESPERA) && !fin;

    temporizador #(
        .TIMEOUT (TIMEOUT)
    ) u_temporizador (
        .clk       (clk),
        .reset     (reset),
        .borrar    (borrar_tmp),
        .habilitar (habilitar_tmp),
        .vencido   (vencido)
    );

    // A timeout marks the sweep bad but leaves suma and ultima untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            limite <= '0;
            valor  <= '0;
            suma   <= '0;
            ultima <= '0;
            error  <= 1'b0;
        end else begin
            unique case (estado)
                REPOSO: begin
                    if (ir) begin
                        limite <= n_valores;
                        valor  <= '0;
                        suma   <= '0;
                        ultima <= '0;
                        error  <= 1'b0;
                    end
                end
                ESPERA: begin
                    if (fin) begin
                        ultima <= cuenta;
                        suma   <= suma + W_SUMA'(cuenta);
                        if (!coincide(cuenta, valor)) begin
                            error <= 1'b1;
                        end
                        if (valor != limite) begin
                            valor <= valor + 1'b1;
                        end
                    end else if (vencido) begin
                        error <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_cuenta1.sv
// Directed and randomized sweeps of control_cuenta1 against a behavioural
// cuenta1 counter whose per-value latency and result are set by the bench.
module tb_control_cuenta1;

    logic       clk;
    logic       reset;
    logic       ir;
    logic [2:0] n_valores;
    logic [2:0] valor;
    logic       start;
    logic [3:0] cuenta;
    logic       fin;
    logic       ocupado;
    logic       hecho;
    logic [6:0] suma;
    logic [3:0] ultima;
    logic       error;

    int compared = 0;
    int failed   = 0;

    // Behaviour of the counter for each valor, chosen by the bench per sweep.
    int         lat [8];
    logic [3:0] ret [8];
    bit         no_fin;

    int         remaining;
    int         item;
    bit         busy;
    logic [2:0] start_q [$];
    int         cyc;
    int         start_cyc;
    int         hecho_cyc;
    int         fin_cyc;
    int         hecho_cnt;

    control_cuenta1 #(
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ir        (ir),
        .n_valores (n_valores),
        .valor     (valor),
        .start     (start),
        .cuenta    (cuenta),
        .fin       (fin),
        .ocupado   (ocupado),
        .hecho     (hecho),
        .suma      (suma),
        .ultima    (ultima),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter model plus monitor; observations precede the model's update.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            busy   = 1'b0;
            fin    = 1'b0;
            cuenta = '0;
        end else begin
            if (start) begin
                start_q.push_back(valor);
                start_cyc = cyc;
            end
            if (hecho) begin
                hecho_cnt++;
                hecho_cyc = cyc;
            end
            fin = 1'b0;
            if (start) begin
                item      = int'(valor);
                remaining = lat[item];
                busy      = !no_fin;
            end else if (busy) begin
                remaining--;
                if (remaining == 0) begin
                    fin     = 1'b1;
                    cuenta  = ret[item];
                    fin_cyc = cyc;
                    busy    = 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_identity();
        for (int v = 0; v < 8; v++) begin
            lat[v] = v + 1;
            ret[v] = 4'(v);
        end
        no_fin = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Pulses ir for one cycle; caller is just after a negedge in REPOSO.
    task automatic applyStimulus(input int n);
        start_q.delete();
        hecho_cnt = 0;
        n_valores = 3'(n);
        ir = 1'b1;
        tick(1);
        ir = 1'b0;
    endtask

    task automatic wait_hecho(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (hecho_cnt != 0) break;
            tick(1);
        end
        checkOutput({tag, "_hecho_seen"}, (hecho_cnt != 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_starts(input string tag, input int count, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (start_q.size() >= count) break;
            tick(1);
        end
        checkOutput({tag, "_starts_seen"}, (start_q.size() >= count) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Expected results are derived from the counter's chosen answers alone.
    task automatic check_sweep(input string tag, input int n);
        int exp_sum;
        int exp_ult;
        int exp_err;
        exp_sum = 0;
        exp_ult = 0;
        exp_err = 0;
        for (int v = 0; v <= n; v++) begin
            exp_sum += int'(ret[v]);
            exp_ult  = int'(ret[v]);
            if (int'(ret[v]) != v) exp_err = 1;
        end
        checkOutput({tag, "_nstarts"}, start_q.size(), n + 1);
        for (int i = 0; i < start_q.size(); i++) begin
            checkOutput($sformatf("%s_valor%0d", tag, i), start_q[i], i);
        end
        checkOutput({tag, "_suma"}, suma, exp_sum);
        checkOutput({tag, "_ultima"}, ultima, exp_ult);
        checkOutput({tag, "_error"}, error, exp_err);
        checkOutput({tag, "_hecho_once"}, hecho_cnt, 1);
        checkOutput({tag, "_ocupado"}, ocupado, 0);
        checkOutput({tag, "_start_idle"}, start, 0);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        ir        = 1'b0;
        n_valores = '0;
        set_identity();
        #13;
        checkOutput("rst_start", start, 0);
        checkOutput("rst_valor", valor, 0);
        checkOutput("rst_ocupado", ocupado, 0);
        checkOutput("rst_hecho", hecho, 0);
        checkOutput("rst_suma", suma, 0);
        checkOutput("rst_ultima", ultima, 0);
        checkOutput("rst_error", error, 0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        tick(2);

        // Basic sweep 0..3.
        applyStimulus(3);
        checkOutput("ir_to_start", start, 1);
        wait_hecho("s3", 200);
        tick(2);
        check_sweep("s3", 3);

        // Full sweep 0..7 with no wrap; hecho follows the last fin by one cycle.
        applyStimulus(7);
        wait_hecho("s7", 300);
        checkOutput("s7_fin_to_hecho", hecho_cyc - fin_cyc, 1);
        tick(2);
        check_sweep("s7", 7);

        // Wrong answer for valor 2: error sticks but the sweep carries on.
        set_identity();
        ret[2] = 4'd3;
        applyStimulus(4);
        wait_starts("bad", 4, 200);
        checkOutput("bad_error_sticky", error, 1);
        wait_hecho("bad", 200);
        tick(2);
        check_sweep("bad", 4);
        checkOutput("bad_suma11", suma, 11);

        // fin arriving on the very cycle the timeout is reached still wins.
        set_identity();
        lat[0] = 16;
        lat[1] = 16;
        applyStimulus(1);
        wait_hecho("edge", 200);
        tick(2);
        check_sweep("edge", 1);

        // Counter never answers: abort after 16 waiting cycles.
        set_identity();
        no_fin = 1'b1;
        applyStimulus(3);
        wait_hecho("tmo", 100);
        checkOutput("tmo_latency", hecho_cyc - start_cyc, 17);
        tick(2);
        checkOutput("tmo_nstarts", start_q.size(), 1);
        checkOutput("tmo_error", error, 1);
        checkOutput("tmo_suma", suma, 0);
        checkOutput("tmo_ultima", ultima, 0);
        checkOutput("tmo_ocupado", ocupado, 0);

        // Reset in the middle of item 2's wait.
        set_identity();
        for (int v = 0; v < 8; v++) lat[v] = 6;
        applyStimulus(4);
        wait_starts("rmid", 3, 100);
        tick(2);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rmid_start", start, 0);
        checkOutput("rmid_valor", valor, 0);
        checkOutput("rmid_ocupado", ocupado, 0);
        checkOutput("rmid_suma", suma, 0);
        checkOutput("rmid_ultima", ultima, 0);
        checkOutput("rmid_error", error, 0);
        tick(2);
        reset = 1'b0;
        tick(10);
        checkOutput("rmid_no_hecho", hecho_cnt, 0);
        checkOutput("rmid_idle", ocupado, 0);
        set_identity();
        applyStimulus(2);
        wait_hecho("rnew", 100);
        tick(2);
        check_sweep("rnew", 2);

        // ir held high: no restart until the sweep has returned to REPOSO.
        set_identity();
        start_q.delete();
        hecho_cnt = 0;
        n_valores = 3'd2;
        ir = 1'b1;
        wait_hecho("hold", 100);
        checkOutput("hold_nstarts", start_q.size(), 3);
        checkOutput("hold_busy_fin", ocupado, 1);
        tick(1);
        checkOutput("hold_reposo", ocupado, 0);
        tick(1);
        checkOutput("hold_restart", start_q.size(), 4);
        ir = 1'b0;
        hecho_cnt = 0;
        wait_hecho("hold2", 100);
        tick(2);
        checkOutput("hold2_nstarts", start_q.size(), 6);
        checkOutput("hold2_suma", suma, 3);

        // Randomized sweeps: random limit, latency and occasional wrong answers.
        for (int k = 0; k < 6; k++) begin
            n = int'($urandom_range(0, 7));
            no_fin = 1'b0;
            for (int v = 0; v < 8; v++) begin
                lat[v] = int'($urandom_range(1, 10));
                ret[v] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(v);
            end
            applyStimulus(n);
            wait_hecho($sformatf("rnd%0d", k), 300);
            tick(2);
            check_sweep($sformatf("rnd%0d", k), n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
